// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle sequencer in front of an external 32-bit ALU.
// Accepts one request at a time, checks its ARM condition against NZCV,
// drives registered ALU operands for one pass (two passes for ADD64),
// then holds the result and flags on a valid/ready response channel.
module alu_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [3:0]  req_cond,
    input  logic        req_setflags,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [31:0] req_a_hi,
    input  logic [31:0] req_b_hi,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic        alu_carry,
    output logic [1:0]  alu_op,
    input  logic [31:0] alu_out,
    input  logic        alu_c,
    input  logic        alu_v,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [31:0] rsp_result_hi,
    output logic        rsp_executed,
    output logic [3:0]  flags
);

    typedef enum logic [1:0] {IDLE, EXEC_LO, EXEC_HI, RESP} state_t;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_ADC   = 3'b001;
    localparam logic [2:0] OP_SUB   = 3'b010;
    localparam logic [2:0] OP_AND   = 3'b011;
    localparam logic [2:0] OP_ROR   = 3'b100;
    localparam logic [2:0] OP_ADD64 = 3'b101;
    localparam logic [2:0] OP_CMP   = 3'b110;
    localparam logic [2:0] OP_NOP   = 3'b111;

    state_t      state, state_nxt;
    logic [2:0]  op_q;
    logic        sf_q;
    logic [31:0] a_hi_q, b_hi_q;
    logic [4:0]  amt_q;
    logic        start_exec;
    logic [3:0]  new_flags;

    // ARM condition check on {N,Z,C,V}; codes E and F both mean "always".
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'h0:    return z;
            4'h1:    return !z;
            4'h2:    return c;
            4'h3:    return !c;
            4'h4:    return n;
            4'h5:    return !n;
            4'h6:    return v;
            4'h7:    return !v;
            4'h8:    return c && !z;
            4'h9:    return !c || z;
            4'hA:    return n == v;
            4'hB:    return n != v;
            4'hC:    return !z && (n == v);
            4'hD:    return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    assign start_exec = cond_pass(req_cond, flags) && (req_op != OP_NOP);
    assign req_ready  = (state == IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state always uses non-blocking assignment so every
        // register samples the pre-edge values of the others.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch forms.
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = start_exec ? EXEC_LO : RESP;
            EXEC_LO: state_nxt = (op_q == OP_ADD64) ? EXEC_HI : RESP;
            EXEC_HI: state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Flag values that the final ALU pass would produce.
    always_comb begin
        new_flags = flags;
        if (state == EXEC_HI) begin
            new_flags = {alu_out[31], (rsp_result == '0) && (alu_out == '0), alu_c, alu_v};
        end else begin
            new_flags[3] = alu_out[31];
            new_flags[2] = (alu_out == '0);
            case (op_q)
                OP_ADD, OP_ADC: new_flags[1:0] = {alu_c, alu_v};
                OP_SUB, OP_CMP: new_flags[1:0] = {~alu_c, alu_v};
                OP_ROR:         if (amt_q != '0) new_flags[1] = alu_out[31];
                default:        ;
            endcase
        end
    end

    // Request latch, ALU drive, result capture, flags and response valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q          <= OP_NOP;
            sf_q          <= 1'b0;
            a_hi_q        <= '0;
            b_hi_q        <= '0;
            amt_q         <= '0;
            alu_in1       <= '0;
            alu_in2       <= '0;
            alu_op        <= 2'b00;
            alu_carry     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_result    <= '0;
            rsp_result_hi <= '0;
            rsp_executed  <= 1'b0;
            flags         <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    op_q          <= req_op;
                    sf_q          <= req_setflags;
                    a_hi_q        <= req_a_hi;
                    b_hi_q        <= req_b_hi;
                    amt_q         <= req_b[4:0];
                    rsp_result    <= '0;
                    rsp_result_hi <= '0;
                    rsp_executed  <= start_exec;
                    if (!start_exec) begin
                        rsp_valid <= 1'b1;
                    end else begin
                        alu_carry <= 1'b0;
                        case (req_op)
                            OP_ADC: begin
                                alu_in1 <= req_a;  alu_in2 <= req_b;
                                alu_op  <= 2'b00;  alu_carry <= flags[1];
                            end
                            OP_SUB, OP_CMP: begin
                                alu_in1 <= req_b;  alu_in2 <= req_a;  alu_op <= 2'b01;
                            end
                            OP_AND: begin
                                alu_in1 <= req_a;  alu_in2 <= req_b;  alu_op <= 2'b10;
                            end
                            OP_ROR: begin
                                alu_in1 <= {27'b0, req_b[4:0]};  alu_in2 <= req_a;
                                alu_op  <= 2'b11;
                            end
                            default: begin
                                alu_in1 <= req_a;  alu_in2 <= req_b;  alu_op <= 2'b00;
                            end
                        endcase
                    end
                end
                EXEC_LO: begin
                    rsp_result <= (op_q == OP_CMP) ? '0 : alu_out;
                    if (op_q == OP_ADD64) begin
                        alu_in1   <= a_hi_q;
                        alu_in2   <= b_hi_q;
                        alu_op    <= 2'b00;
                        alu_carry <= alu_c;
                    end else begin
                        rsp_valid <= 1'b1;
                        if (sf_q || op_q == OP_CMP) flags <= new_flags;
                    end
                end
                EXEC_HI: begin
                    rsp_result_hi <= alu_out;
                    rsp_valid     <= 1'b1;
                    if (sf_q) flags <= new_flags;
                end
                RESP: if (rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: a behavioural ALU drives alu_out,
// a spec-level model predicts each response, and a per-cycle compare process
// checks handshake, latency, results and flags.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [3:0]  req_cond = '0;
    logic        req_setflags = 1'b0;
    logic [31:0] req_a = '0, req_b = '0, req_a_hi = '0, req_b_hi = '0;
    logic [31:0] alu_in1, alu_in2, alu_out;
    logic        alu_carry, alu_c, alu_v;
    logic [1:0]  alu_op;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_result, rsp_result_hi;
    logic        rsp_executed;
    logic [3:0]  flags;

    alu_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_cond(req_cond), .req_setflags(req_setflags),
        .req_a(req_a), .req_b(req_b), .req_a_hi(req_a_hi), .req_b_hi(req_b_hi),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_carry(alu_carry), .alu_op(alu_op),
        .alu_out(alu_out), .alu_c(alu_c), .alu_v(alu_v),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_result_hi(rsp_result_hi), .rsp_executed(rsp_executed), .flags(flags)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: 00 add+cin, 01 in2-in1 (c = borrow), 10 and, 11 ror in2 by in1.
    logic [32:0] alu_sum;
    logic [63:0] alu_rr;
    always_comb begin
        alu_out = '0; alu_c = 1'b0; alu_v = 1'b0; alu_sum = '0; alu_rr = '0;
        case (alu_op)
            2'b00: begin
                alu_sum = {1'b0, alu_in1} + {1'b0, alu_in2} + {32'b0, alu_carry};
                alu_out = alu_sum[31:0];
                alu_c   = alu_sum[32];
                alu_v   = (alu_in1[31] == alu_in2[31]) && (alu_out[31] != alu_in1[31]);
            end
            2'b01: begin
                alu_out = alu_in2 - alu_in1;
                alu_c   = (alu_in2 < alu_in1);
                alu_v   = (alu_in2[31] != alu_in1[31]) && (alu_out[31] != alu_in2[31]);
            end
            2'b10: alu_out = alu_in1 & alu_in2;
            default: begin
                alu_rr  = {alu_in2, alu_in2} >> alu_in1[4:0];
                alu_out = alu_rr[31:0];
            end
        endcase
    end

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic        exec;
        logic [3:0]  flags;
        int          lat;
    } exp_t;

    // Architectural model: what the response must be, from operands and NZCV.
    function automatic exp_t model(input logic [2:0] op, input logic [3:0] cond,
                                   input logic sf, input logic [31:0] a, b, ahi, bhi,
                                   input logic [3:0] f);
        exp_t        m;
        logic        n, z, c, v, ok, nc, nv;
        logic [31:0] r;
        logic [32:0] s33;
        logic [63:0] r64;
        logic [64:0] s65;
        {n, z, c, v} = f;
        case (cond)
            4'h0: ok = z;          4'h1: ok = !z;
            4'h2: ok = c;          4'h3: ok = !c;
            4'h4: ok = n;          4'h5: ok = !n;
            4'h6: ok = v;          4'h7: ok = !v;
            4'h8: ok = c && !z;    4'h9: ok = !c || z;
            4'hA: ok = (n == v);   4'hB: ok = (n != v);
            4'hC: ok = !z && (n == v);
            4'hD: ok = z || (n != v);
            default: ok = 1'b1;
        endcase
        m.res = '0; m.hi = '0; m.exec = 1'b0; m.flags = f; m.lat = 1;
        if (!ok || op == 3'd7) return m;
        m.exec = 1'b1; m.lat = 2;
        nc = c; nv = v; r = '0; r64 = '0;
        case (op)
            3'd0, 3'd1: begin
                s33 = {1'b0, a} + {1'b0, b} + ((op == 3'd1) ? {32'b0, c} : 33'd0);
                r = s33[31:0]; nc = s33[32];
                nv = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'd2, 3'd6: begin
                r = a - b; nc = (a >= b);
                nv = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'd3: r = a & b;
            3'd4: begin
                r64 = {a, a} >> b[4:0]; r = r64[31:0];
                if (b[4:0] != 5'd0) nc = r[31];
            end
            default: begin
                s65 = {1'b0, ahi, a} + {1'b0, bhi, b};
                r64 = s65[63:0]; r = r64[31:0]; m.hi = r64[63:32];
                nc = s65[64]; nv = (ahi[31] == bhi[31]) && (r64[63] != ahi[31]);
                m.lat = 3;
            end
        endcase
        if (sf || op == 3'd6)
            m.flags = (op == 3'd5) ? {r64[63], r64 == 64'd0, nc, nv} : {r[31], r == 32'd0, nc, nv};
        m.res = (op == 3'd6) ? 32'd0 : r;
        return m;
    endfunction

    int   n_vec = 0, n_err = 0;
    int   cyc = 0, acc = 0;
    bit   chk_en = 1'b0, pending = 1'b0;
    logic [3:0] model_flags = '0;
    exp_t exp_r;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, want);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle compare against the model, sampled mid-cycle.
    always @(negedge clk) begin
        logic ev;
        if (chk_en) begin
            ev = pending && (cyc - acc >= exp_r.lat - 1);
            check("req_ready", {63'b0, req_ready}, {63'b0, !pending});
            check("rsp_valid", {63'b0, rsp_valid}, {63'b0, ev});
            check("flags", {60'b0, flags}, {60'b0, ev ? exp_r.flags : model_flags});
            if (ev) begin
                check("rsp_result", {32'b0, rsp_result}, {32'b0, exp_r.res});
                check("rsp_result_hi", {32'b0, rsp_result_hi}, {32'b0, exp_r.hi});
                check("rsp_executed", {63'b0, rsp_executed}, {63'b0, exp_r.exec});
            end
        end
    end

    // Issue one request, wait for its response (optionally back-pressured),
    // and pin the response to hand-computed literals when given.
    task automatic run_op(input logic [2:0] op, input logic [3:0] cond, input logic sf,
                          input logic [31:0] a, b, ahi, bhi, input int hold,
                          input bit lit_en, input logic [31:0] lres, lhi,
                          input logic lexec, input logic [3:0] lflags);
        int n;
        @(negedge clk);
        req_op = op; req_cond = cond; req_setflags = sf;
        req_a = a; req_b = b; req_a_hi = ahi; req_b_hi = bhi;
        req_valid = 1'b1;
        rsp_ready = (hold == 0);
        exp_r = model(op, cond, sf, a, b, ahi, bhi, model_flags);
        @(posedge clk); #1;
        req_valid = 1'b0;
        acc = cyc;
        pending = 1'b1;
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!rsp_valid && n < 8);
        if (!rsp_valid) begin
            check("rsp_timeout", 64'd0, 64'd1);
            pending = 1'b0;
            rsp_ready = 1'b1;
            return;
        end
        if (lit_en) begin
            check("lit_result", {32'b0, rsp_result}, {32'b0, lres});
            check("lit_result_hi", {32'b0, rsp_result_hi}, {32'b0, lhi});
            check("lit_executed", {63'b0, rsp_executed}, {63'b0, lexec});
            check("lit_flags", {60'b0, flags}, {60'b0, lflags});
        end
        repeat (hold) @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        pending = 1'b0;
        model_flags = exp_r.flags;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rsp_valid"}, {63'b0, rsp_valid}, 64'd0);
        check({tag, "_req_ready"}, {63'b0, req_ready}, 64'd1);
        check({tag, "_flags"}, {60'b0, flags}, 64'd0);
        check({tag, "_result"}, {rsp_result_hi, rsp_result}, 64'd0);
        check({tag, "_executed"}, {63'b0, rsp_executed}, 64'd0);
        check({tag, "_alu_in"}, {alu_in2, alu_in1}, 64'd0);
        check({tag, "_alu_ctl"}, {61'b0, alu_op, alu_carry}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1 chk_en = 1'b1;

        //     op    cond  sf  a             b             a_hi          b_hi  hold lit res           hi            ex    nzcv
        run_op(3'd0, 4'hE, 1, 32'h7FFFFFFF, 32'h00000001, 32'h0,        32'h0, 0, 1, 32'h80000000, 32'h0,        1'b1, 4'b1001);
        run_op(3'd2, 4'hE, 1, 32'd5,        32'd5,        32'h0,        32'h0, 0, 1, 32'h0,        32'h0,        1'b1, 4'b0110);
        run_op(3'd2, 4'hE, 1, 32'd3,        32'd5,        32'h0,        32'h0, 0, 1, 32'hFFFFFFFE, 32'h0,        1'b1, 4'b1000);
        run_op(3'd5, 4'hE, 1, 32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h0, 0, 1, 32'h0,        32'h00000001, 1'b1, 4'b0000);
        run_op(3'd4, 4'hE, 1, 32'h00000001, 32'd1,        32'h0,        32'h0, 0, 1, 32'h80000000, 32'h0,        1'b1, 4'b1010);
        run_op(3'd4, 4'hE, 1, 32'h12345678, 32'd32,       32'h0,        32'h0, 0, 1, 32'h12345678, 32'h0,        1'b1, 4'b0010);
        run_op(3'd3, 4'hF, 1, 32'h000000F0, 32'h0000000F, 32'h0,        32'h0, 0, 1, 32'h0,        32'h0,        1'b1, 4'b0110);
        run_op(3'd0, 4'hE, 1, 32'd1,        32'd1,        32'h0,        32'h0, 0, 1, 32'd2,        32'h0,        1'b1, 4'b0000);
        run_op(3'd0, 4'h0, 1, 32'd7,        32'd8,        32'h0,        32'h0, 0, 1, 32'h0,        32'h0,        1'b0, 4'b0000);
        run_op(3'd0, 4'h1, 1, 32'd2,        32'd3,        32'h0,        32'h0, 0, 1, 32'd5,        32'h0,        1'b1, 4'b0000);
        run_op(3'd6, 4'hE, 0, 32'd5,        32'd3,        32'h0,        32'h0, 0, 1, 32'h0,        32'h0,        1'b1, 4'b0010);
        run_op(3'd1, 4'hE, 1, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h0, 3, 1, 32'h0,        32'h0,        1'b1, 4'b0110);
        run_op(3'd7, 4'hE, 1, 32'd9,        32'd9,        32'h0,        32'h0, 0, 1, 32'h0,        32'h0,        1'b0, 4'b0110);
        run_op(3'd0, 4'hC, 1, 32'd1,        32'd1,        32'h0,        32'h0, 0, 0, 32'h0,        32'h0,        1'b0, 4'b0);
        run_op(3'd2, 4'hE, 1, 32'h80000000, 32'd1,        32'h0,        32'h0, 0, 1, 32'h7FFFFFFF, 32'h0,        1'b1, 4'b0011);
        run_op(3'd0, 4'h6, 0, 32'd1,        32'd1,        32'h0,        32'h0, 0, 0, 32'h0,        32'h0,        1'b0, 4'b0);
        run_op(3'd0, 4'hA, 1, 32'd1,        32'd1,        32'h0,        32'h0, 0, 0, 32'h0,        32'h0,        1'b0, 4'b0);
        run_op(3'd0, 4'hB, 0, 32'd4,        32'd4,        32'h0,        32'h0, 1, 0, 32'h0,        32'h0,        1'b0, 4'b0);
        run_op(3'd0, 4'h8, 0, 32'd1,        32'd2,        32'h0,        32'h0, 0, 0, 32'h0,        32'h0,        1'b0, 4'b0);
        run_op(3'd5, 4'hE, 1, 32'hFFFFFFFF, 32'h1,        32'h7FFFFFFF, 32'h0, 0, 1, 32'h0,        32'h80000000, 1'b1, 4'b1001);

        // Reset asserted while the second pass of an ADD64 is on the ALU.
        @(negedge clk);
        req_op = 3'd5; req_cond = 4'hE; req_setflags = 1'b1;
        req_a = 32'h1; req_b = 32'h2; req_a_hi = 32'h3; req_b_hi = 32'h4;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("inreset");
        @(negedge clk);
        rst_n = 1'b1;
        model_flags = 4'b0000;
        pending = 1'b0;
        @(posedge clk); #1 chk_en = 1'b1;
        repeat (3) @(negedge clk);

        run_op(3'd0, 4'h0, 1, 32'd1,  32'd1,  32'h0, 32'h0, 0, 1, 32'h0,  32'h0, 1'b0, 4'b0000);
        run_op(3'd0, 4'hE, 1, 32'd10, 32'd20, 32'h0, 32'h0, 0, 1, 32'd30, 32'h0, 1'b1, 4'b0000);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
